// File: rtl/pipe_stage_chain_if.sv
// rtl/pipe_stage_chain_if.sv - valid/ready handshake bundle for one pipe_stage_chain boundary
interface pipe_stage_chain_if #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 1
);
  logic              flush_i;
  logic              valid_i;
  logic              ready_o;
  logic [DATA_W-1:0] data_i;
  logic              valid_o;
  logic              ready_i;
  logic [DATA_W-1:0] data_o;
  logic [CNT_W-1:0]  count_o;

  // master drives the chain (producer/consumer side), slave is the chain itself
  modport master (
    output flush_i, valid_i, data_i, ready_i,
    input  ready_o, valid_o, data_o, count_o
  );

  modport slave (
    input  flush_i, valid_i, data_i, ready_i,
    output ready_o, valid_o, data_o, count_o
  );
endinterface

// File: rtl/pipe_stage_chain.sv
// rtl/pipe_stage_chain.sv - elastic valid/ready register chain with flush and occupancy count; PIPE_SKID_EN adds a skid register per slice
module pipe_stage_chain #(
  parameter int DATA_W = 64,
  parameter int STAGES = 1,
  parameter int CNT_W  = $clog2(2*STAGES+1)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  pipe_stage_chain_if.slave bus
);

  if (STAGES < 1) begin : g_bad_stages
    $error("pipe_stage_chain: STAGES must be at least 1");
  end

  // Main-register valid/data of every slice; slice STAGES-1 is the tail
  logic [STAGES-1:0] slice_v;
  logic [DATA_W-1:0] slice_d [STAGES];
  // up_rdy[k]: slice k takes an entry from its upstream this cycle if one is offered
  logic [STAGES-1:0] up_rdy;

  logic             in_fire;
  logic             out_fire;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

`ifndef PIPE_SKID_EN
  // Ready ripples back from the consumer through every full slice
  always_comb begin : ready_chain
    logic r;
    r = bus.ready_i;
    for (int k = STAGES-1; k >= 0; k--) begin
      up_rdy[k] = !slice_v[k] || r;
      r = up_rdy[k];
    end
  end
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    logic              in_v;
    logic [DATA_W-1:0] in_d;

    if (k == 0) begin : g_head
      assign in_v = bus.valid_i;
      assign in_d = bus.data_i;
    end else begin : g_body
      assign in_v = slice_v[k-1];
      assign in_d = slice_d[k-1];
    end

`ifdef PIPE_SKID_EN
    logic              dn_rdy;
    logic              m_v_q, m_v_d, s_v_q, s_v_d;
    logic [DATA_W-1:0] m_d_q, m_d_d, s_d_q, s_d_d;
    logic              fwd;
    logic              acc;

    if (k == STAGES-1) begin : g_tail
      assign dn_rdy = bus.ready_i;
    end else begin : g_mid
      assign dn_rdy = up_rdy[k+1];
    end

    // Registered ready: only a full skid register refuses new entries
    assign up_rdy[k] = !s_v_q;
    assign fwd       = m_v_q && dn_rdy;
    assign acc       = in_v && !s_v_q;

    // Skid refills main when main moves on; a stalled full main diverts the arrival into skid
    always_comb begin
      m_v_d = m_v_q;
      m_d_d = m_d_q;
      s_v_d = s_v_q;
      s_d_d = s_d_q;
      if (s_v_q) begin
        if (fwd) begin
          m_d_d = s_d_q;
          s_v_d = 1'b0;
        end
      end else if (!m_v_q || fwd) begin
        m_v_d = acc;
        if (acc) m_d_d = in_d;
      end else if (acc) begin
        s_v_d = 1'b1;
        s_d_d = in_d;
      end
      if (bus.flush_i) begin
        m_v_d = 1'b0;
        s_v_d = 1'b0;
      end
    end

    // Main and skid registers of this slice
    always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
        m_v_q <= 1'b0;
        m_d_q <= '0;
        s_v_q <= 1'b0;
        s_d_q <= '0;
      end else begin
        m_v_q <= m_v_d;
        m_d_q <= m_d_d;
        s_v_q <= s_v_d;
        s_d_q <= s_d_d;
      end
    end

    assign slice_v[k] = m_v_q;
    assign slice_d[k] = m_d_q;
`else
    logic              v_q, v_d;
    logic [DATA_W-1:0] d_q, d_d;

    // Take whatever upstream offers whenever this slice is empty or draining; data held when empty
    always_comb begin
      v_d = v_q;
      d_d = d_q;
      if (up_rdy[k]) begin
        v_d = in_v;
        if (in_v) d_d = in_d;
      end
      if (bus.flush_i) v_d = 1'b0;
    end

    // Main register of this slice
    always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
        v_q <= 1'b0;
        d_q <= '0;
      end else begin
        v_q <= v_d;
        d_q <= d_d;
      end
    end

    assign slice_v[k] = v_q;
    assign slice_d[k] = d_q;
`endif
  end

  assign bus.ready_o = up_rdy[0];
  assign bus.valid_o = slice_v[STAGES-1];
  assign bus.data_o  = slice_d[STAGES-1];
  assign bus.count_o = count_q;

  assign in_fire  = bus.valid_i && bus.ready_o;
  assign out_fire = bus.valid_o && bus.ready_i;

  // Occupancy tracks accepted minus delivered entries; flush empties it
  always_comb begin
    count_d = count_q;
    if (bus.flush_i) begin
      count_d = '0;
    end else if (in_fire && !out_fire) begin
      count_d = count_q + CNT_W'(1);
    end else if (!in_fire && out_fire) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Occupancy register
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) count_q <= '0;
    else          count_q <= count_d;
  end

endmodule
